// File: rtl/miriscv_mem_arbiter.sv
// Two-to-one round-robin arbiter merging instruction-fetch and load/store
// requests onto one req/gnt/rvalid memory port with in-order response routing.
module miriscv_mem_arbiter #(
    parameter int XLEN        = 32,
    parameter int OUTSTANDING = 2
) (
    input  logic              clk_i,
    input  logic              arstn_i,

    input  logic              instr_req_i,
    input  logic [XLEN-1:0]   instr_addr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [XLEN-1:0]   instr_rdata_o,

    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [XLEN/8-1:0] data_be_i,
    input  logic [XLEN-1:0]   data_addr_i,
    input  logic [XLEN-1:0]   data_wdata_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic [XLEN-1:0]   data_rdata_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,

    output logic              arb_err_o
);

    localparam int CW = $clog2(OUTSTANDING + 1);
    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

    localparam logic OWN_INSTR = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    logic [OUTSTANDING-1:0] r_owner;
    logic [PW-1:0]          r_wptr;
    logic [PW-1:0]          r_rptr;
    logic [CW-1:0]          r_count;
    logic                   r_lock;
    logic                   r_lock_owner;
    logic                   r_last_grant;
    logic                   r_arb_err;

    logic w_full;
    logic w_sel;
    logic w_sel_req;
    logic w_req;
    logic w_push;
    logic w_pop;
    logic w_head;

    function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    // Full is judged on the registered count: a pop this cycle frees a slot only next cycle.
    assign w_full = (r_count == CW'(OUTSTANDING));

    always_comb begin
        w_sel = OWN_INSTR;
        if (r_lock)
            w_sel = r_lock_owner;
        else if (instr_req_i && data_req_i)
            w_sel = ~r_last_grant;
        else if (data_req_i)
            w_sel = OWN_DATA;
    end

    assign w_sel_req = (w_sel == OWN_DATA) ? data_req_i : instr_req_i;
    assign w_req     = arstn_i & ~w_full & w_sel_req;
    assign w_push    = w_req & mem_gnt_i;
    assign w_pop     = mem_rvalid_i & (r_count != '0);
    assign w_head    = r_owner[r_rptr];

    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (w_req) begin
            if (w_sel == OWN_DATA) begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_be_o    = '1;
                mem_addr_o  = instr_addr_i;
            end
        end
    end

    assign mem_req_o      = w_req;
    assign instr_gnt_o    = w_push & (w_sel == OWN_INSTR);
    assign data_gnt_o     = w_push & (w_sel == OWN_DATA);
    assign instr_rvalid_o = w_pop & (w_head == OWN_INSTR);
    assign data_rvalid_o  = w_pop & (w_head == OWN_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign arb_err_o      = r_arb_err;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_owner      <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_lock       <= 1'b0;
            r_lock_owner <= OWN_INSTR;
            r_last_grant <= OWN_DATA;
            r_arb_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_owner[r_wptr] <= w_sel;
                r_wptr          <= f_ptr_inc(r_wptr);
                r_last_grant    <= w_sel;
            end
            if (w_pop)
                r_rptr <= f_ptr_inc(r_rptr);

            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (!w_push && w_pop)
                r_count <= r_count - CW'(1);

            // An offered-but-refused request pins the selection until it is accepted.
            if (w_req && !mem_gnt_i) begin
                r_lock       <= 1'b1;
                r_lock_owner <= w_sel;
            end else if (w_push) begin
                r_lock       <= 1'b0;
            end

            if (mem_rvalid_i && (r_count == '0))
                r_arb_err <= 1'b1;
        end
    end

endmodule
